tt_fpga_pin_conditioner: RTL and testbench
==========================================

# tt_fpga_pin_conditioner

Parametrised board-side pin conditioner between the FPGA pads and a Tiny Tapeout user project in the FPGA top. It synchronises `ui` and `uio` inputs, debounces the board reset button, and generates a stretched user reset. It also tristates the `uio` outputs while the user project is held in reset. It replaces direct wiring of `BTN_N` to the project reset.

## Interface
Parameters:
- `UI_WIDTH`, 8: width of dedicated inputs.
- `UIO_WIDTH`, 8: width of bidirectional pins.
- `SYNC_STAGES`, 2: synchroniser depth; legal ≥2.
- `DEBOUNCE_CYCLES`, 1024: consecutive stable cycles needed to accept a button level; legal ≥1.
- `POR_CYCLES`, 16: user-reset stretch length in cycles; legal ≥1.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset of this block.
- `btn_n_raw`  in  1  raw, bouncing reset button; low = pressed.
- `ui_raw`  in  UI_WIDTH  asynchronous dedicated inputs.
- `uio_raw`  in  UIO_WIDTH  asynchronous pad inputs (SB_IO D_IN_0).
- `uio_out_in`  in  UIO_WIDTH  user project `uio_out`.
- `uio_oe_in`  in  UIO_WIDTH  user project `uio_oe`.
- `ui_sync`  out  UI_WIDTH  synchronised `ui_raw`.
- `uio_sync`  out  UIO_WIDTH  synchronised `uio_raw`.
- `uio_out_pad`  out  UIO_WIDTH  to SB_IO D_OUT_0.
- `uio_oe_pad`  out  UIO_WIDTH  to SB_IO OUTPUT_ENABLE.
- `user_rst_n`  out  1  registered reset to the user project.
- `btn_event`  out  1  one-cycle pulse on an accepted press.

## Operation
- Synchronisers: `SYNC_STAGES` flops per bit on `ui_raw`, `uio_raw` and `btn_n_raw`. Data chains reset to 0. The button chain resets to 1 (released).
- Debouncer: stable level `btn_db` resets to 1. Counter `cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits and resets to 0. On each edge:
  - If synced button == `btn_db`: `cnt`←0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_db`←synced value, `cnt`←0.
  - Else: `cnt`←`cnt`+1.
  - Any bounce restarts the count.
- `btn_event`: registered; high for exactly one cycle after the edge on which `btn_db` goes 1→0. Never asserted on release.
- Reset FSM (flop-based, one-hot or binary), states HOLD / RUN / PRESSED. Stretch counter `por_cnt` resets to 0.
  - Async reset: state = HOLD, `por_cnt` = 0.
  - HOLD: if `btn_db`=0 → PRESSED, `por_cnt`←0. Else if `por_cnt == POR_CYCLES-1` → RUN. Else `por_cnt`++.
  - RUN: if `btn_db`=0 → PRESSED.
  - PRESSED: if `btn_db`=1 → HOLD with `por_cnt`←0.
- `user_rst_n`: registered and equal to (next state == RUN), so it is glitch-free. Reset value 0.
- Pad gating (combinational):
  - `uio_oe_pad = uio_oe_in & {UIO_WIDTH{user_rst_n}}`, so pads are tristated whenever the user project is in reset.
  - `uio_out_pad = uio_out_in`.
- Reset values: `ui_sync`=0, `uio_sync`=0, `user_rst_n`=0, `btn_event`=0, `uio_oe_pad`=0.

## Timing
- Input latency: a change on `ui_raw`/`uio_raw` stable before edge 1 appears on `*_sync` after edge `SYNC_STAGES`.
- Power-up, button released: `user_rst_n` rises on the `POR_CYCLES`-th rising edge after `rst_n` deasserts.
- Press accepted when the button is held continuously:
  - Button falls before edge 1; `btn_db` falls on edge `SYNC_STAGES+DEBOUNCE_CYCLES`.
  - `btn_event` is high during the following cycle.
  - `user_rst_n` falls on edge `SYNC_STAGES+DEBOUNCE_CYCLES+1`.
- Release: `btn_db` rises after the same `SYNC_STAGES+DEBOUNCE_CYCLES` edges. `user_rst_n` rises `POR_CYCLES+1` edges after that.
- Simultaneous events:
  - A press during HOLD aborts the stretch, and the count restarts from 0 after release.
  - A bounce shorter than `DEBOUNCE_CYCLES` has no effect.
- `rst_n` asserted mid-operation: all flops clear immediately, without waiting for `clk`. `user_rst_n` and `uio_oe_pad` go to 0 in the same instant.

## Test plan
All scenarios use UI_WIDTH=8, UIO_WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, POR_CYCLES=8.
- Power-up: hold `rst_n`=0 for 3 cycles, then release with the button high → all outputs 0 during reset; `user_rst_n`=1 exactly at edge 8 after release; `btn_event` never high.
- Sync latency: in RUN, `ui_raw` 0x00→0xA5 and `uio_raw` 0x00→0x3C → `ui_sync`=0xA5 and `uio_sync`=0x3C after edge 2, not before.
- Bounce reject and press:
  - Button low 3 cycles, high 1, then low 3 → no `btn_event`, `user_rst_n` stays 1.
  - Button held low → `btn_event` is a single pulse after edge 6; `user_rst_n`=0 at edge 7.
- Release and stretch: from PRESSED, button high → `btn_db`=1 at edge 6; `user_rst_n`=1 at edge 6+9=15; no `btn_event`.
- Pad gating: `uio_oe_in`=0xFF, `uio_out_in`=0x5A → `uio_oe_pad`=0x00 in HOLD/PRESSED and 0xFF in RUN; `uio_out_pad`=0x5A throughout.
- Async reset mid-debounce: assert `rst_n`=0 while `cnt`=2 with the button low → `user_rst_n`, `btn_event`, `uio_oe_pad` = 0 without a clock edge. After release with the button high, the full 8-cycle stretch repeats.

Source files
------------

// File: rtl/tt_fpga_pin_conditioner_if.sv
// Pad-side bundle of the pin conditioner: raw board inputs, user-project
// outputs, and the conditioned signals handed back to pads and project.
interface tt_fpga_pin_conditioner_if #(
   parameter int UI_WIDTH  = 8,
   parameter int UIO_WIDTH = 8
);
   logic                 btn_n_raw;
   logic [UI_WIDTH-1:0]  ui_raw;
   logic [UIO_WIDTH-1:0] uio_raw;
   logic [UIO_WIDTH-1:0] uio_out_in;
   logic [UIO_WIDTH-1:0] uio_oe_in;
   logic [UI_WIDTH-1:0]  ui_sync;
   logic [UIO_WIDTH-1:0] uio_sync;
   logic [UIO_WIDTH-1:0] uio_out_pad;
   logic [UIO_WIDTH-1:0] uio_oe_pad;
   logic                 user_rst_n;
   logic                 btn_event;

   modport master (
      output btn_n_raw, ui_raw, uio_raw, uio_out_in, uio_oe_in,
      input  ui_sync, uio_sync, uio_out_pad, uio_oe_pad, user_rst_n, btn_event
   );

   modport slave (
      input  btn_n_raw, ui_raw, uio_raw, uio_out_in, uio_oe_in,
      output ui_sync, uio_sync, uio_out_pad, uio_oe_pad, user_rst_n, btn_event
   );
endinterface

// File: rtl/tt_fpga_pin_conditioner.sv
// Board-side conditioner: input synchronisers, reset-button debouncer and a
// stretched, glitch-free user reset that also tristates the uio pads.
module tt_fpga_pin_conditioner #(
   parameter int UI_WIDTH        = 8,
   parameter int UIO_WIDTH       = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int POR_CYCLES      = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   tt_fpga_pin_conditioner_if.slave     bus
);
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int POR_W = $clog2(POR_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PRESSED = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0][UI_WIDTH-1:0]  r_ui_chain;
   logic [SYNC_STAGES-1:0][UIO_WIDTH-1:0] r_uio_chain;
   logic [SYNC_STAGES-1:0]                r_btn_chain;
   logic                                  w_btn_s;

   logic                                  r_btn_db;
   logic [DB_W-1:0]                       r_db_cnt;
   logic                                  r_btn_event;

   state_t                                r_state;
   state_t                                w_state_next;
   logic [POR_W-1:0]                      r_por_cnt;
   logic [POR_W-1:0]                      w_por_cnt_next;
   logic                                  r_user_rst_n;

   // Element 0 is the first flop; the button chain idles at "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ui_chain  <= '0;
         r_uio_chain <= '0;
         r_btn_chain <= '1;
      end else begin
         r_ui_chain  <= {r_ui_chain[SYNC_STAGES-2:0], bus.ui_raw};
         r_uio_chain <= {r_uio_chain[SYNC_STAGES-2:0], bus.uio_raw};
         r_btn_chain <= {r_btn_chain[SYNC_STAGES-2:0], bus.btn_n_raw};
      end
   end

   assign w_btn_s = r_btn_chain[SYNC_STAGES-1];

   // Any sample matching the accepted level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_db    <= 1'b1;
         r_db_cnt    <= '0;
         r_btn_event <= 1'b0;
      end else begin
         r_btn_event <= 1'b0;
         if (w_btn_s == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_btn_db    <= w_btn_s;
            r_db_cnt    <= '0;
            r_btn_event <= ~w_btn_s;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_por_cnt_next = r_por_cnt;
      case (r_state)
         ST_HOLD: begin
            if (!r_btn_db) begin
               w_state_next   = ST_PRESSED;
               w_por_cnt_next = '0;
            end else if (r_por_cnt == POR_LAST) begin
               w_state_next = ST_RUN;
            end else begin
               w_por_cnt_next = r_por_cnt + POR_W'(1);
            end
         end
         ST_RUN: begin
            if (!r_btn_db) begin
               w_state_next = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (r_btn_db) begin
               w_state_next   = ST_HOLD;
               w_por_cnt_next = '0;
            end
         end
         default: begin
            w_state_next   = ST_HOLD;
            w_por_cnt_next = '0;
         end
      endcase
   end

   // Registering the decoded next state keeps user_rst_n free of decode glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_HOLD;
         r_por_cnt    <= '0;
         r_user_rst_n <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_por_cnt    <= w_por_cnt_next;
         r_user_rst_n <= (w_state_next == ST_RUN);
      end
   end

   assign bus.ui_sync     = r_ui_chain[SYNC_STAGES-1];
   assign bus.uio_sync    = r_uio_chain[SYNC_STAGES-1];
   assign bus.uio_out_pad = bus.uio_out_in;
   assign bus.uio_oe_pad  = bus.uio_oe_in & {UIO_WIDTH{r_user_rst_n}};
   assign bus.user_rst_n  = r_user_rst_n;
   assign bus.btn_event   = r_btn_event;
endmodule

// File: tb/tb_tt_fpga_pin_conditioner.sv
// Scoreboard bench for tt_fpga_pin_conditioner: expectations are queued with
// the cycle they are due and compared on the falling edge of that cycle.
module tb_tt_fpga_pin_conditioner;
   localparam int UI_W   = 8;
   localparam int UIO_W  = 8;
   localparam int SYNC_N = 2;
   localparam int DB_N   = 4;
   localparam int POR_N  = 8;

   localparam int SEL_UI   = 0;
   localparam int SEL_UIO  = 1;
   localparam int SEL_URST = 2;
   localparam int SEL_EVT  = 3;
   localparam int SEL_OE   = 4;
   localparam int SEL_OUT  = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tt_fpga_pin_conditioner_if #(.UI_WIDTH(UI_W), .UIO_WIDTH(UIO_W)) bus ();

   tt_fpga_pin_conditioner #(
      .UI_WIDTH        (UI_W),
      .UIO_WIDTH       (UIO_W),
      .SYNC_STAGES     (SYNC_N),
      .DEBOUNCE_CYCLES (DB_N),
      .POR_CYCLES      (POR_N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned cyc;
      int          sel;
      logic [31:0] exp;
      string       tag;
   } sb_t;

   sb_t         sb_q[$];
   int unsigned cyc   = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_UI:   return 32'(bus.ui_sync);
         SEL_UIO:  return 32'(bus.uio_sync);
         SEL_URST: return 32'(bus.user_rst_n);
         SEL_EVT:  return 32'(bus.btn_event);
         SEL_OE:   return 32'(bus.uio_oe_pad);
         default:  return 32'(bus.uio_out_pad);
      endcase
   endfunction

   task automatic expect_range(input int unsigned base, input int k0, input int k1,
                               input int sel, input logic [31:0] v, input string tag);
      sb_t e;
      for (int k = k0; k <= k1; k++) begin
         e.cyc = base + k;
         e.sel = sel;
         e.exp = v;
         e.tag = $sformatf("%s@%0d", tag, k);
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc == cyc) begin
            check_value(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
            sb_q.delete(i);
         end else if (sb_q[i].cyc < cyc) begin
            check_value({sb_q[i].tag, "_late"}, cyc, sb_q[i].cyc);
            sb_q.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic expect_powerup(input int unsigned base, input string tag);
      expect_range(base, 1, POR_N - 1, SEL_URST, 32'd0, {tag, "_urst_lo"});
      expect_range(base, POR_N, POR_N, SEL_URST, 32'd1, {tag, "_urst_hi"});
      expect_range(base, 1, POR_N, SEL_EVT, 32'd0, {tag, "_evt"});
      expect_range(base, POR_N - 1, POR_N - 1, SEL_OE, 32'h00, {tag, "_oe_lo"});
      expect_range(base, POR_N, POR_N, SEL_OE, 32'hFF, {tag, "_oe_hi"});
   endtask

   int unsigned c;

   initial begin
      rst_n          = 1'b1;
      bus.btn_n_raw  = 1'b1;
      bus.ui_raw     = '0;
      bus.uio_raw    = '0;
      bus.uio_out_in = 8'h5A;
      bus.uio_oe_in  = 8'hFF;
      #1 rst_n = 1'b0;
      tick(3);
      check_value("rst_ui_sync", 32'(bus.ui_sync), 32'h0);
      check_value("rst_uio_sync", 32'(bus.uio_sync), 32'h0);
      check_value("rst_user_rst_n", 32'(bus.user_rst_n), 32'h0);
      check_value("rst_btn_event", 32'(bus.btn_event), 32'h0);
      check_value("rst_uio_oe_pad", 32'(bus.uio_oe_pad), 32'h0);
      check_value("rst_uio_out_pad", 32'(bus.uio_out_pad), 32'h5A);

      // power-up stretch
      rst_n = 1'b1;
      c = cyc;
      expect_powerup(c, "pwr");
      expect_range(c, 1, POR_N, SEL_OUT, 32'h5A, "pwr_out");
      tick(POR_N);

      // synchroniser latency
      c = cyc;
      bus.ui_raw  = 8'hA5;
      bus.uio_raw = 8'h3C;
      expect_range(c, 1, SYNC_N - 1, SEL_UI, 32'h00, "ui_early");
      expect_range(c, SYNC_N, SYNC_N, SEL_UI, 32'hA5, "ui_sync");
      expect_range(c, 1, SYNC_N - 1, SEL_UIO, 32'h00, "uio_early");
      expect_range(c, SYNC_N, SYNC_N, SEL_UIO, 32'h3C, "uio_sync");
      tick(3);

      // bounce: 3 low, 1 high, 3 low is rejected
      c = cyc;
      expect_range(c, 1, 14, SEL_URST, 32'd1, "bnc_urst");
      expect_range(c, 1, 14, SEL_EVT, 32'd0, "bnc_evt");
      expect_range(c, 1, 14, SEL_OE, 32'hFF, "bnc_oe");
      bus.btn_n_raw = 1'b0;
      tick(3);
      bus.btn_n_raw = 1'b1;
      tick(1);
      bus.btn_n_raw = 1'b0;
      tick(3);
      bus.btn_n_raw = 1'b1;
      tick(8);

      // held press
      c = cyc;
      bus.btn_n_raw = 1'b0;
      expect_range(c, 1, SYNC_N + DB_N - 1, SEL_EVT, 32'd0, "prs_evt_pre");
      expect_range(c, SYNC_N + DB_N, SYNC_N + DB_N, SEL_EVT, 32'd1, "prs_evt");
      expect_range(c, SYNC_N + DB_N + 1, 10, SEL_EVT, 32'd0, "prs_evt_post");
      expect_range(c, 1, SYNC_N + DB_N, SEL_URST, 32'd1, "prs_urst_hi");
      expect_range(c, SYNC_N + DB_N + 1, 10, SEL_URST, 32'd0, "prs_urst_lo");
      expect_range(c, SYNC_N + DB_N, SYNC_N + DB_N, SEL_OE, 32'hFF, "prs_oe_hi");
      expect_range(c, SYNC_N + DB_N + 1, 10, SEL_OE, 32'h00, "prs_oe_lo");
      expect_range(c, 10, 10, SEL_OUT, 32'h5A, "prs_out");
      tick(11);

      // release and stretch
      c = cyc;
      bus.btn_n_raw = 1'b1;
      expect_range(c, 1, SYNC_N + DB_N + POR_N, SEL_URST, 32'd0, "rel_urst_lo");
      expect_range(c, SYNC_N + DB_N + POR_N + 1, SYNC_N + DB_N + POR_N + 2, SEL_URST, 32'd1, "rel_urst_hi");
      expect_range(c, 1, SYNC_N + DB_N + POR_N + 2, SEL_EVT, 32'd0, "rel_evt");
      expect_range(c, SYNC_N + DB_N + POR_N, SYNC_N + DB_N + POR_N, SEL_OE, 32'h00, "rel_oe_lo");
      expect_range(c, SYNC_N + DB_N + POR_N + 1, SYNC_N + DB_N + POR_N + 1, SEL_OE, 32'hFF, "rel_oe_hi");
      expect_range(c, SYNC_N + DB_N + POR_N + 1, SYNC_N + DB_N + POR_N + 1, SEL_OUT, 32'h5A, "rel_out");
      tick(SYNC_N + DB_N + POR_N + 3);

      // async reset while the debounce count is at 2
      c = cyc;
      bus.btn_n_raw = 1'b0;
      expect_range(c, 1, 3, SEL_URST, 32'd1, "ar_urst_pre");
      tick(4);
      #1 rst_n = 1'b0;
      #1;
      check_value("ar_user_rst_n", 32'(bus.user_rst_n), 32'h0);
      check_value("ar_btn_event", 32'(bus.btn_event), 32'h0);
      check_value("ar_uio_oe_pad", 32'(bus.uio_oe_pad), 32'h0);
      check_value("ar_ui_sync", 32'(bus.ui_sync), 32'h0);
      tick(2);
      bus.btn_n_raw = 1'b1;
      tick(1);
      rst_n = 1'b1;
      c = cyc;
      expect_powerup(c, "ar_pwr");
      tick(POR_N + 1);

      for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(posedge clk);
      #6;
      check_value("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
